// File: rtl/fmac_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: a packet becomes readable only once its EOP word
// lands error-free; errored or overflowed packets rewind the speculative write pointer.
module fmac_rx_pkt_fifo #(
    parameter int WIDTH    = 256,
    parameter int DEPTH    = 4096,
    parameter int PTR      = 12,
    parameter int AFULL_TH = 4032,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             flush,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             wr_eop,
    input  logic             wr_err,
    output logic             wrfull,
    output logic             wr_afull,
    output logic [PTR:0]     wrusedw,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             q_eop,
    output logic             rdempty,
    output logic [PTR:0]     rdusedw,
    output logic [PTR:0]     pkt_cnt,
    output logic [15:0]      drop_cnt
);
    typedef logic [PTR:0] ptr_t;

    ptr_t             wr_ptr, cwr_ptr, rd_ptr;
    logic             ovf, pf_vld, pf_nxt;
    logic             pop, pop_eop, wr_acc, commit, drop, store, load;
    logic [PTR-1:0]   rd_addr;
    logic [WIDTH:0]   mem [DEPTH];
    logic [DEPTH-1:0] eop_tag;

    assign wrusedw  = wr_ptr - rd_ptr;
    assign rdusedw  = cwr_ptr - rd_ptr;
    assign wrfull   = (wrusedw == ptr_t'(DEPTH));
    assign wr_afull = (wrusedw >= ptr_t'(AFULL_TH));
    assign rdempty  = (FWFT != 0) ? !pf_vld : (rdusedw == '0);

    always_comb begin
        pop     = rdreq & ~rdempty;
        // Shadow of the EOP tags so packet accounting on pop needs no RAM read.
        pop_eop = eop_tag[rd_ptr[PTR-1:0]];
        // A pop frees a slot on this edge, so a write at wrfull still goes in alongside it.
        wr_acc  = wrreq & (~wrfull | pop);
        commit  = wrreq & wr_eop & wr_acc & ~wr_err & ~ovf;
        drop    = wrreq & wr_eop & ~commit;
        store   = wr_acc & (~wr_eop | commit);
        rd_addr = rd_ptr[PTR-1:0];
        load    = pop;
        pf_nxt  = 1'b0;
        if (FWFT != 0) begin
            // The head word already sits in q; a pop prefetches the one after it.
            if (pop) rd_addr = rd_ptr[PTR-1:0] + 1'b1;
            load   = pop ? (rdusedw > ptr_t'(1)) : (~pf_vld & (rdusedw != '0));
            pf_nxt = pop ? (rdusedw > ptr_t'(1)) : (pf_vld | (rdusedw != '0));
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr   <= '0;
            cwr_ptr  <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            pf_vld   <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
            q        <= '0;
            q_eop    <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            cwr_ptr  <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            pf_vld   <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
            q        <= '0;
            q_eop    <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr  <= wr_ptr + 1'b1;
                cwr_ptr <= wr_ptr + 1'b1;
            end else if (drop) begin
                wr_ptr  <= cwr_ptr;
            end else if (store) begin
                wr_ptr  <= wr_ptr + 1'b1;
            end

            if (wrreq & wr_eop)      ovf <= 1'b0;
            else if (wrreq & ~wr_acc) ovf <= 1'b1;

            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({commit, pop & pop_eop})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase

            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;

            if (load) {q_eop, q} <= mem[rd_addr];
            pf_vld <= pf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (store && !flush) begin
            mem[wr_ptr[PTR-1:0]]     <= {wr_eop, data};
            eop_tag[wr_ptr[PTR-1:0]] <= wr_eop;
        end
    end

endmodule

// File: tb/tb_fmac_rx_pkt_fifo.sv
// Bench for fmac_rx_pkt_fifo: registered-read and FWFT instances share stimulus and are
// each compared every cycle against a packet-queue reference model.
module tb_fmac_rx_pkt_fifo;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int P  = 4;
    localparam int AF = 12;

    logic         clk = 1'b0;
    logic         reset_ = 1'b0;
    logic         flush = 1'b0;
    logic         wrreq = 1'b0;
    logic         wr_eop = 1'b0;
    logic         wr_err = 1'b0;
    logic         rdreq = 1'b0;
    logic [W-1:0] data = '0;

    logic [1:0]   wrfull_o, wr_afull_o, rdempty_o, q_eop_o;
    logic [P:0]   wrusedw_o [2];
    logic [P:0]   rdusedw_o [2];
    logic [P:0]   pkt_o [2];
    logic [W-1:0] q_o [2];
    logic [15:0]  drop_o [2];

    always #5 clk = ~clk;

    fmac_rx_pkt_fifo #(.WIDTH(W), .DEPTH(D), .PTR(P), .AFULL_TH(AF), .FWFT(0)) dut0 (
        .clk(clk), .reset_(reset_), .flush(flush), .wrreq(wrreq), .data(data),
        .wr_eop(wr_eop), .wr_err(wr_err), .wrfull(wrfull_o[0]), .wr_afull(wr_afull_o[0]),
        .wrusedw(wrusedw_o[0]), .rdreq(rdreq), .q(q_o[0]), .q_eop(q_eop_o[0]),
        .rdempty(rdempty_o[0]), .rdusedw(rdusedw_o[0]), .pkt_cnt(pkt_o[0]), .drop_cnt(drop_o[0])
    );

    fmac_rx_pkt_fifo #(.WIDTH(W), .DEPTH(D), .PTR(P), .AFULL_TH(AF), .FWFT(1)) dut1 (
        .clk(clk), .reset_(reset_), .flush(flush), .wrreq(wrreq), .data(data),
        .wr_eop(wr_eop), .wr_err(wr_err), .wrfull(wrfull_o[1]), .wr_afull(wr_afull_o[1]),
        .wrusedw(wrusedw_o[1]), .rdreq(rdreq), .q(q_o[1]), .q_eop(q_eop_o[1]),
        .rdempty(rdempty_o[1]), .rdusedw(rdusedw_o[1]), .pkt_cnt(pkt_o[1]), .drop_cnt(drop_o[1])
    );

    // Reference: committed words (readable, in order) and the pending partial packet.
    logic [32:0] cq [2][$];
    logic [32:0] pq [2][$];
    bit          ovf_m [2];
    bit          vis [2];
    int          drop_m [2];
    logic [32:0] qx [2];
    int          npass = 0;
    int          ntot = 0;

    task automatic chk(input string tag, input int m, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s dut%0d: got %0h expected %0h", tag, m, obs, exp);
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            cq[m].delete();
            pq[m].delete();
            ovf_m[m]  = 1'b0;
            vis[m]    = 1'b0;
            drop_m[m] = 0;
            qx[m]     = '0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int          csz;
            bit          pop, full, acc;
            logic [32:0] w;
            if (flush) begin
                cq[m].delete();
                pq[m].delete();
                ovf_m[m]  = 1'b0;
                vis[m]    = 1'b0;
                drop_m[m] = 0;
                qx[m]     = '0;
            end else begin
                csz  = cq[m].size();
                pop  = rdreq && ((m == 0) ? (csz != 0) : vis[m]);
                full = (csz + pq[m].size()) == D;
                acc  = wrreq && (!full || pop);
                if (pop) begin
                    w = cq[m].pop_front();
                    if (m == 0) qx[m] = w;
                end
                // FWFT head becomes visible one edge after words are committed.
                if (m == 1) vis[m] = vis[m] ? (!pop || csz > 1) : (csz > 0);
                if (wrreq && wr_eop) begin
                    if (acc && !wr_err && !ovf_m[m]) begin
                        pq[m].push_back({1'b1, data});
                        while (pq[m].size() != 0) cq[m].push_back(pq[m].pop_front());
                    end else begin
                        pq[m].delete();
                        if (drop_m[m] != 16'hFFFF) drop_m[m]++;
                    end
                    ovf_m[m] = 1'b0;
                end else if (acc) begin
                    pq[m].push_back({1'b0, data});
                end else if (wrreq) begin
                    ovf_m[m] = 1'b1;
                end
                if (m == 1 && vis[m]) qx[m] = cq[m][0];
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int csz, used, pk;
            csz  = cq[m].size();
            used = csz + pq[m].size();
            pk   = 0;
            for (int i = 0; i < csz; i++) pk += int'(cq[m][i][32]);
            chk("wrusedw",  m, wrusedw_o[m],  used);
            chk("rdusedw",  m, rdusedw_o[m],  csz);
            chk("wrfull",   m, wrfull_o[m],   used == D);
            chk("wr_afull", m, wr_afull_o[m], used >= AF);
            chk("rdempty",  m, rdempty_o[m],  (m == 0) ? (csz == 0) : !vis[m]);
            chk("pkt_cnt",  m, pkt_o[m],      pk);
            chk("drop_cnt", m, drop_o[m],     drop_m[m]);
            chk("q",        m, q_o[m],        qx[m][31:0]);
            chk("q_eop",    m, q_eop_o[m],    qx[m][32]);
        end
    endtask

    task automatic cyc(input bit w, input logic [31:0] d, input bit e, input bit er, input bit r);
        wrreq  = w;
        data   = d;
        wr_eop = e;
        wr_err = er;
        rdreq  = r;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc(0, 0, 0, 0, 0);
        flush = 1'b0;
    endtask

    initial begin
        model_clear();
        #12 check_all();
        @(negedge clk) reset_ = 1'b1;

        // 4-word packet, then read it back from both read modes
        for (int i = 1; i <= 4; i++) cyc(1, i, i == 4, 0, 0);
        chk("t1_rdempty_eop", 0, rdempty_o[0], 0);
        chk("t1_rdempty_eop", 1, rdempty_o[1], 1);
        cyc(0, 0, 0, 0, 0);
        chk("t1_rdempty_late", 1, rdempty_o[1], 0);
        for (int m = 0; m < 2; m++) begin
            chk("t1_pkt", m, pkt_o[m], 1);
            chk("t1_rdusedw", m, rdusedw_o[m], 4);
        end
        repeat (6) cyc(0, 0, 0, 0, 1);
        for (int m = 0; m < 2; m++) chk("t1_pkt_end", m, pkt_o[m], 0);

        // good packet followed by an errored one
        do_flush();
        for (int i = 0; i < 3; i++) cyc(1, 32'h10 + i, i == 2, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 32'h20 + i, i == 4, i == 4, 0);
        for (int m = 0; m < 2; m++) begin
            chk("t2_drop", m, drop_o[m], 1);
            chk("t2_wrusedw", m, wrusedw_o[m], 3);
            chk("t2_pkt", m, pkt_o[m], 1);
        end
        repeat (5) cyc(0, 0, 0, 0, 1);

        // oversize packet overflows and is dropped; next packet is fine
        do_flush();
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h100 + i, i == 19, 0, 0);
            if (i == 11) chk("t3_afull", 0, wr_afull_o[0], 1);
            if (i == 15) chk("t3_full", 1, wrfull_o[1], 1);
        end
        for (int m = 0; m < 2; m++) begin
            chk("t3_drop", m, drop_o[m], 1);
            chk("t3_wrusedw", m, wrusedw_o[m], 0);
            chk("t3_rdempty", m, rdempty_o[m], 1);
        end
        cyc(1, 32'hA1, 0, 0, 0);
        cyc(1, 32'hA2, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 1);

        // 100 back-to-back 8-word packets with continuous reads
        do_flush();
        for (int p = 0; p < 100; p++)
            for (int k = 0; k < 8; k++) cyc(1, $urandom, k == 7, 0, 1);
        repeat (12) cyc(0, 0, 0, 0, 1);
        for (int m = 0; m < 2; m++) begin
            chk("t4_drop", m, drop_o[m], 0);
            chk("t4_rdusedw", m, rdusedw_o[m], 0);
        end

        // full FIFO: EOP pop and EOP commit on the same edge
        do_flush();
        for (int i = 0; i < 16; i++) cyc(1, 32'h200 + i, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h300, 1, 0, 1);
        for (int m = 0; m < 2; m++) begin
            chk("t5_wrusedw", m, wrusedw_o[m], 16);
            chk("t5_pkt", m, pkt_o[m], 16);
        end
        repeat (18) cyc(0, 0, 0, 0, 1);

        // async reset mid-packet
        do_flush();
        cyc(1, 32'h400, 0, 0, 0);
        cyc(1, 32'h401, 0, 0, 0);
        #2 reset_ = 1'b0;
        model_clear();
        #1 check_all();
        @(negedge clk) reset_ = 1'b1;
        cyc(1, 32'h410, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1);
        for (int m = 0; m < 2; m++) chk("t6_q_after_reset", m, q_o[m], 32'h410);

        // flush mid-packet
        cyc(1, 32'h500, 0, 0, 0);
        flush = 1'b1;
        cyc(1, 32'h501, 0, 0, 1);
        flush = 1'b0;
        for (int m = 0; m < 2; m++) chk("t6_flush_wrusedw", m, wrusedw_o[m], 0);
        cyc(1, 32'h510, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1);
        for (int m = 0; m < 2; m++) chk("t6_q_after_flush", m, q_o[m], 32'h510);

        // randomized traffic with phases of slow and fast draining
        do_flush();
        for (int i = 0; i < 1500; i++) begin
            int rp;
            rp = ((i / 200) % 2 == 0) ? 4 : 1;
            flush = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, rp) == 0);
            flush = 1'b0;
        end
        repeat (20) cyc(0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
